// File: rtl/pwrbtn_press_decoder.sv
// Power-button press decoder: turns a debounced button level plus a slow tick
// strobe into short/long press pulses, with a post-release lockout window.
module pwrbtn_press_decoder #(
    parameter logic PRESS_LEVEL     = 1'b0,
    parameter int   SHORT_MIN_TICKS = 2,
    parameter int   LONG_TICKS      = 4000,
    parameter int   BLANK_TICKS     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick_en,
    input  logic       btn_db,
    output logic       short_press,
    output logic       long_press,
    output logic       btn_held,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        BLANK   = 2'd3
    } state_t;

    generate
        if (LONG_TICKS < 1 || LONG_TICKS > 65535 || BLANK_TICKS < 1 ||
            BLANK_TICKS > 65535 || SHORT_MIN_TICKS < 0 ||
            SHORT_MIN_TICKS >= LONG_TICKS) begin : g_param_chk
            $error("pwrbtn_press_decoder: illegal tick parameters");
        end
    endgenerate

    localparam logic [16:0] LONG_L  = 17'(LONG_TICKS);
    localparam logic [16:0] BLANK_L = 17'(BLANK_TICKS);
    localparam logic [15:0] SHORT_L = 16'(SHORT_MIN_TICKS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        btn_q, btn_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        held_q, held_d;
    logic        pressed;
    logic [16:0] cnt_inc;

    assign pressed = (btn_q == PRESS_LEVEL);
    // One bit wider so a compare against 65535 never sees a wrapped value.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        btn_d   = btn_db;
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (pressed) state_d = PRESSED;
                end
                PRESSED: begin
                    // Release beats a coincident tick and is judged on the old count.
                    if (!pressed) begin
                        cnt_d = '0;
                        if (cnt_q >= SHORT_L) begin
                            short_d = 1'b1;
                            state_d = BLANK;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (tick_en) begin
                        cnt_d = cnt_inc[15:0];
                        if (cnt_inc == LONG_L) begin
                            long_d  = 1'b1;
                            state_d = HELD;
                        end
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (tick_en) begin
                        if (cnt_inc == BLANK_L) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_inc[15:0];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        held_d = (state_d == PRESSED) || (state_d == HELD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            btn_q   <= ~PRESS_LEVEL;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

    assign short_press = short_q;
    assign long_press  = long_q;
    assign btn_held    = held_q;
    assign state_o     = state_q;

endmodule

// File: doc/pwrbtn_press_decoder.md
PWRBTN_PRESS_DECODER -- requirements
Module: pwrbtn_press_decoder

Interface
REQ-001 SHALL have parameter PRESS_LEVEL, default 1'b0, the btn_db level meaning "pressed" (front-panel button active-low).
REQ-002 SHALL have parameter SHORT_MIN_TICKS, default 2, the minimum ticks held for a valid short press.
REQ-003 SHALL have parameter LONG_TICKS, default 4000, the ticks held for a long press (4 s at a 1 ms tick).
REQ-004 SHALL have parameter BLANK_TICKS, default 100, the ticks of post-release lockout.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-007 SHALL have port en, input, 1, the decoder enable; low forces IDLE.
REQ-008 SHALL have port tick_en, input, 1, a one-clk-wide time-base strobe (e.g. 1 ms).
REQ-009 SHALL have port btn_db, input, 1, the debounced button level from the upstream debouncer.
REQ-010 SHALL have port short_press, output, 1, a 1-clk pulse on a valid short press release.
REQ-011 SHALL have port long_press, output, 1, a 1-clk pulse when the hold reaches LONG_TICKS.
REQ-012 SHALL have port btn_held, output, 1, high while state is PRESSED or HELD.
REQ-013 SHALL have port state_o, output, 2, the current state: IDLE=0, PRESSED=1, HELD=2, BLANK=3.

Function
REQ-014 SHALL register btn_db once per clk into btn_q; pressed = (btn_q == PRESS_LEVEL); all decisions use pressed.
REQ-015 SHALL use a 16-bit tick counter cnt; LONG_TICKS and BLANK_TICKS SHALL be 1..65535, and SHORT_MIN_TICKS SHALL be < LONG_TICKS (elaboration check).
REQ-016 IDLE: when pressed, SHALL go to PRESSED with cnt=0; otherwise SHALL stay in IDLE with cnt=0.
REQ-017 PRESSED, pressed and tick_en: SHALL compute cnt+1; if it equals LONG_TICKS, SHALL go to HELD and pulse long_press on the next clk, else cnt<=cnt+1.
REQ-018 PRESSED, not pressed: if cnt >= SHORT_MIN_TICKS, SHALL pulse short_press next clk and go to BLANK with cnt=0; else SHALL go to IDLE with no pulse.
REQ-019 Release and tick_en in the same clk: release SHALL win; the decision SHALL use the un-incremented cnt.
REQ-020 HELD: cnt SHALL freeze; on release SHALL go to BLANK with cnt=0 and no short_press.
REQ-021 BLANK: cnt SHALL increment on tick_en; on the tick where cnt+1 == BLANK_TICKS, SHALL go to IDLE; presses SHALL be ignored.
REQ-022 If still pressed when BLANK expires, SHALL enter PRESSED next clk via IDLE (no re-arm without IDLE).
REQ-023 short_press and long_press SHALL be registered, never both high, and at most one pulse each per press.
REQ-024 en low SHALL force IDLE and cnt=0, suppress pulses, and deassert btn_held next clk; btn_q SHALL keep sampling.
REQ-025 btn_held and state_o SHALL be registered state decodes with no combinational path from btn_db.

Reset
REQ-026 With rst high at a clk edge: state=IDLE, cnt=0, btn_q=~PRESS_LEVEL, short_press=0, long_press=0, btn_held=0, state_o=0.
REQ-027 rst SHALL override en, tick_en and btn_db; reset mid-PRESSED or mid-HELD SHALL emit no pulse.
REQ-028 First decision after rst release SHALL occur one clk after btn_q samples a press (2 clk latency btn_db->state).

Verification
REQ-029 Defaults: press btn_db=0 for 1 tick, release -> no pulse, state_o returns 0, btn_held high only while pressed.
REQ-030 Press 10 ticks, release -> exactly one short_press clk; state_o=3 for 100 ticks; a re-press at tick 50 of BLANK is ignored.
REQ-031 Hold 4000 ticks -> long_press single clk after the 4000th tick, state_o=2; release -> BLANK, no short_press.
REQ-032 Release coincident with the tick that would make cnt=2 (cnt=1) -> no short_press, IDLE.
REQ-033 rst high for 1 clk at cnt=3999 in PRESSED -> all outputs 0, state_o=0 next clk, no long_press ever.
REQ-034 en low for 1 clk mid-PRESSED with button still held -> IDLE, then PRESSED restarts with cnt=0; long_press only after 4000 further ticks.
